// File: rtl/bank_pkg.sv
// Shared types and default geometry for the single-bank burst master.
package bank_pkg;

   localparam int unsigned DEFAULT_DEVICE_WIDTH = 4;
   localparam int unsigned DEFAULT_COLWIDTH     = 10;
   localparam int unsigned DEFAULT_CHWIDTH      = 5;
   localparam int unsigned DEFAULT_BL           = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } state_e;

   // Width of a beat index for a burst of bl beats (never narrower than 1).
   function automatic int unsigned beat_idx_width(input int unsigned bl);
      return (bl > 1) ? $clog2(bl) : 1;
   endfunction

endpackage

// File: rtl/bank_beat_deser.sv
// Burst capture register: writes one DEVICE_WIDTH beat per cycle at a given
// beat index, with a synchronous clear taking priority over capture.
module bank_beat_deser
   import bank_pkg::*;
#(
   parameter int unsigned DEVICE_WIDTH = DEFAULT_DEVICE_WIDTH,
   parameter int unsigned BL           = DEFAULT_BL
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clr,
   input  logic                                cap_en,
   input  logic [beat_idx_width(BL)-1:0]       cap_idx,
   input  logic [DEVICE_WIDTH-1:0]             cap_data,
   output logic [BL*DEVICE_WIDTH-1:0]          data
);

   localparam int unsigned BW = beat_idx_width(BL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (clr) begin
         data <= '0;
      end else if (cap_en) begin
         for (int unsigned k = 0; k < BL; k++) begin
            if (cap_idx == BW'(k)) begin
               data[k*DEVICE_WIDTH +: DEVICE_WIDTH] <= cap_data;
            end
         end
      end
   end

endmodule

// File: rtl/bank_burst_master.sv
// Burst initiator for one DRAM bank: turns BL-beat read/write requests into
// single-beat bank accesses and returns assembled read bursts.
module bank_burst_master
   import bank_pkg::*;
#(
   parameter int unsigned DEVICE_WIDTH = DEFAULT_DEVICE_WIDTH,
   parameter int unsigned COLWIDTH     = DEFAULT_COLWIDTH,
   parameter int unsigned CHWIDTH      = DEFAULT_CHWIDTH,
   parameter int unsigned BL           = DEFAULT_BL
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [CHWIDTH-1:0]           req_row,
   input  logic [COLWIDTH-1:0]          req_col,
   input  logic [BL*DEVICE_WIDTH-1:0]   req_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [BL*DEVICE_WIDTH-1:0]   rsp_rdata,
   output logic                         rd_o_wr,
   output logic [CHWIDTH-1:0]           row,
   output logic [COLWIDTH-1:0]          column,
   output logic [DEVICE_WIDTH-1:0]      dqin,
   input  logic [DEVICE_WIDTH-1:0]      dqout
);

   localparam int unsigned BW   = beat_idx_width(BL);
   localparam int unsigned BUSW = BL * DEVICE_WIDTH;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BL - 1);

   state_e                  state;
   logic [BW-1:0]           beat;
   logic [CHWIDTH-1:0]      row_q;
   logic [COLWIDTH-1:0]     col_q;
   logic [BUSW-1:0]         wdata_q;

   logic                    accept_c;
   logic                    last_c;
   logic [BW-1:0]           beat_nxt_c;
   logic [COLWIDTH-1:0]     col_nxt_c;
   logic [DEVICE_WIDTH-1:0] wbeat_nxt_c;
   logic                    clr_c;
   logic                    cap_en_c;
   logic [BW-1:0]           cap_idx_c;

   // Next-beat address/data and read-capture control.
   always_comb begin
      accept_c    = req_valid && req_ready;
      last_c      = (beat == LAST_BEAT);
      beat_nxt_c  = beat + BW'(1);
      col_nxt_c   = col_q + COLWIDTH'(beat_nxt_c);
      wbeat_nxt_c = '0;
      for (int unsigned k = 0; k < BL; k++) begin
         if (beat_nxt_c == BW'(k)) begin
            wbeat_nxt_c = wdata_q[k*DEVICE_WIDTH +: DEVICE_WIDTH];
         end
      end
      clr_c     = accept_c && !req_write;
      cap_en_c  = 1'b0;
      cap_idx_c = '0;
      // dqout lags the address by one edge, so capture the previous beat.
      if (state == READ && beat != '0) begin
         cap_en_c  = 1'b1;
         cap_idx_c = beat - BW'(1);
      end else if (state == DRAIN) begin
         cap_en_c  = 1'b1;
         cap_idx_c = LAST_BEAT;
      end
   end

   // Burst sequencer with registered handshake and bank-port outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat      <= '0;
         row_q     <= '0;
         col_q     <= '0;
         wdata_q   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rd_o_wr   <= 1'b0;
         row       <= '0;
         column    <= '0;
         dqin      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  row_q     <= req_row;
                  col_q     <= req_col;
                  wdata_q   <= req_wdata;
                  beat      <= '0;
                  req_ready <= 1'b0;
                  rd_o_wr   <= req_write;
                  row       <= req_row;
                  column    <= req_col;
                  dqin      <= req_write ? req_wdata[DEVICE_WIDTH-1:0] : '0;
                  state     <= req_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (last_c) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rd_o_wr   <= 1'b0;
                  row       <= '0;
                  column    <= '0;
                  dqin      <= '0;
               end else begin
                  beat   <= beat_nxt_c;
                  column <= col_nxt_c;
                  dqin   <= wbeat_nxt_c;
               end
            end
            READ: begin
               if (last_c) begin
                  state  <= DRAIN;
                  row    <= '0;
                  column <= '0;
               end else begin
                  beat   <= beat_nxt_c;
                  column <= col_nxt_c;
               end
            end
            DRAIN: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rd_o_wr   <= 1'b0;
               row       <= '0;
               column    <= '0;
               dqin      <= '0;
            end
         endcase
      end
   end

   bank_beat_deser #(
      .DEVICE_WIDTH (DEVICE_WIDTH),
      .BL           (BL)
   ) u_deser (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_c),
      .cap_en   (cap_en_c),
      .cap_idx  (cap_idx_c),
      .cap_data (dqout),
      .data     (rsp_rdata)
   );

endmodule

// File: tb/tb_bank_burst_master.sv
// Self-checking bench for bank_burst_master: behavioural bank, transaction-level
// memory reference, directed table, reset/stall/back-to-back sequences, random bursts.
module tb_bank_burst_master;

   localparam int unsigned DW   = 4;
   localparam int unsigned CW   = 10;
   localparam int unsigned RW   = 5;
   localparam int unsigned BL   = 8;
   localparam int unsigned BUSW = BL * DW;
   localparam int unsigned AW   = RW + CW;
   localparam int unsigned NMEM = 1 << AW;

   logic            clk;
   logic            rst_n;
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [RW-1:0]   req_row;
   logic [CW-1:0]   req_col;
   logic [BUSW-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [BUSW-1:0] rsp_rdata;
   logic            rd_o_wr;
   logic [RW-1:0]   row;
   logic [CW-1:0]   column;
   logic [DW-1:0]   dqin;
   logic [DW-1:0]   dqout;

   int n_checks = 0;
   int n_err    = 0;

   bit [DW-1:0] bank_mem     [NMEM];
   bit          bank_written [NMEM];
   bit [DW-1:0] ref_mem      [NMEM];
   logic [AW-1:0] bank_addr;

   typedef struct {
      bit              write;
      logic [RW-1:0]   row;
      logic [CW-1:0]   col;
      logic [BUSW-1:0] wdata;
      int              stall;
      logic [BUSW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   bank_burst_master #(
      .DEVICE_WIDTH (DW),
      .COLWIDTH     (CW),
      .CHWIDTH      (RW),
      .BL           (BL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_row   (req_row),
      .req_col   (req_col),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rd_o_wr   (rd_o_wr),
      .row       (row),
      .column    (column),
      .dqin      (dqin),
      .dqout     (dqout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pre-existing bank contents before any write.
   function automatic bit [DW-1:0] init_nib(input logic [AW-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]} ^ 4'h6;
   endfunction

   // Bank: registered read of the sampled address, write when rd_o_wr.
   assign bank_addr = {row, column};
   always @(posedge clk) begin
      if (rd_o_wr) begin
         bank_mem[bank_addr]     <= dqin;
         bank_written[bank_addr] <= 1'b1;
      end
      dqout <= bank_written[bank_addr] ? bank_mem[bank_addr] : init_nib(bank_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic ref_write(input logic [RW-1:0] r, input logic [CW-1:0] c,
                            input logic [BUSW-1:0] wd, input int nbeats);
      logic [CW-1:0] cc;
      for (int k = 0; k < nbeats; k++) begin
         cc = c + CW'(k);
         ref_mem[{r, cc}] = wd[k*DW +: DW];
      end
   endtask

   function automatic logic [BUSW-1:0] ref_read(input logic [RW-1:0] r, input logic [CW-1:0] c);
      logic [BUSW-1:0] res;
      logic [CW-1:0]   cc;
      res = '0;
      for (int k = 0; k < BL; k++) begin
         cc = c + CW'(k);
         res[k*DW +: DW] = ref_mem[{r, cc}];
      end
      return res;
   endfunction

   // Wait (bounded) for ready, present a request for one cycle; returns in cycle 1.
   task automatic issue(input bit write, input logic [RW-1:0] r, input logic [CW-1:0] c,
                        input logic [BUSW-1:0] wd, input bit keep);
      int n = 0;
      while (req_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = write;
      req_row   = r;
      req_col   = c;
      req_wdata = wd;
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   // Checks every cycle of a burst starting in cycle 1; ends idle with req_ready high.
   task automatic body(input bit write, input logic [RW-1:0] r, input logic [CW-1:0] c,
                       input logic [BUSW-1:0] wd, input int stall, input logic [BUSW-1:0] exp);
      logic [CW-1:0] ccol;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      for (int k = 0; k < BL; k++) begin
         if (k > 0) @(negedge clk);
         ccol = c + CW'(k);
         chk("bank_rd_o_wr", 32'(rd_o_wr), 32'(write));
         chk("bank_row", 32'(row), 32'(r));
         chk("bank_column", 32'(column), 32'(ccol));
         chk("bank_dqin", 32'(dqin), write ? 32'(wd[k*DW +: DW]) : 32'd0);
         chk("rsp_valid_busy", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      chk("idle_rd_o_wr", 32'(rd_o_wr), 32'd0);
      chk("idle_column", 32'(column), 32'd0);
      chk("idle_row", 32'(row), 32'd0);
      chk("idle_dqin", 32'(dqin), 32'd0);
      if (write) begin
         chk("req_ready_after_write", 32'(req_ready), 32'd1);
         ref_write(r, c, wd, BL);
         return;
      end
      chk("rsp_valid_drain", 32'(rsp_valid), 32'd0);
      chk("req_ready_drain", 32'(req_ready), 32'd0);
      if (stall > 0) rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, exp);
      if (stall > 0) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_row   = RW'($urandom);
         req_col   = CW'($urandom);
         req_wdata = $urandom;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("rsp_valid_stall", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata_stable", rsp_rdata, exp);
            chk("req_ready_stall", 32'(req_ready), 32'd0);
            chk("rd_o_wr_stall", 32'(rd_o_wr), 32'd0);
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
      chk("req_ready_after_read", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BUSW-1:0] exp;
      bit              w;
      logic [RW-1:0]   r;
      logic [CW-1:0]   c;
      logic [BUSW-1:0] wd;
      int              st;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_row   = '0;
      req_col   = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < int'(NMEM); i++) ref_mem[i] = init_nib(AW'(i));

      vecs[0] = '{1'b1, 5'd1, 10'd0,    32'h89ABCDEF, 0, 32'h0};
      vecs[1] = '{1'b0, 5'd1, 10'd0,    32'h0,        0, 32'h89ABCDEF};
      vecs[2] = '{1'b1, 5'd1, 10'd1020, 32'h13579BDF, 0, 32'h0};
      vecs[3] = '{1'b0, 5'd1, 10'd1020, 32'h0,        0, 32'h13579BDF};
      vecs[4] = '{1'b0, 5'd1, 10'd0,    32'h0,        4, 32'h89AB1357};
      vecs[5] = '{1'b1, 5'd3, 10'd512,  32'hDEADBEEF, 0, 32'h0};
      vecs[6] = '{1'b0, 5'd3, 10'd512,  32'h0,        1, 32'hDEADBEEF};

      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rd_o_wr", 32'(rd_o_wr), 32'd0);
      chk("reset_row", 32'(row), 32'd0);
      chk("reset_column", 32'(column), 32'd0);
      chk("reset_dqin", 32'(dqin), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].write, vecs[i].row, vecs[i].col, vecs[i].wdata, 1'b0);
         body(vecs[i].write, vecs[i].row, vecs[i].col, vecs[i].wdata, vecs[i].stall,
              vecs[i].exp_rdata);
      end

      // Reset during write beat 3: beats 3..7 must keep their old contents.
      issue(1'b1, 5'd2, 10'd100, 32'h11111111, 1'b0);
      body(1'b1, 5'd2, 10'd100, 32'h11111111, 0, 32'h0);
      issue(1'b1, 5'd2, 10'd100, 32'hEEEEEEEE, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_column", 32'(column), 32'd103);
      chk("mid_dqin", 32'(dqin), 32'hE);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_rd_o_wr", 32'(rd_o_wr), 32'd0);
      chk("abort_column", 32'(column), 32'd0);
      chk("abort_dqin", 32'(dqin), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      ref_write(5'd2, 10'd100, 32'hEEEEEEEE, 3);
      @(negedge clk);
      issue(1'b0, 5'd2, 10'd100, 32'h0, 1'b0);
      body(1'b0, 5'd2, 10'd100, 32'h0, 0, 32'h11111EEE);

      // Back-to-back: req_valid held high, read request waiting behind a write.
      issue(1'b1, 5'd4, 10'd200, 32'h2468ACE1, 1'b1);
      req_write = 1'b0;
      req_row   = 5'd4;
      req_col   = 10'd200;
      req_wdata = 32'hFFFFFFFF;
      body(1'b1, 5'd4, 10'd200, 32'h2468ACE1, 0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      body(1'b0, 5'd4, 10'd200, 32'h0, 0, 32'h2468ACE1);

      // Random bursts over a few rows, biased towards the column wrap.
      for (int t = 0; t < 40; t++) begin
         w  = 1'($urandom_range(0, 1));
         r  = RW'($urandom_range(0, 3));
         c  = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(1016, 1023)) : CW'($urandom);
         wd = $urandom;
         st = $urandom_range(0, 2);
         exp = w ? 32'h0 : ref_read(r, c);
         issue(w, r, c, wd, 1'b0);
         body(w, r, c, wd, st, exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/bank_burst_master.md
# bank_burst_master

Initiator for a single DRAM bank model: accepts burst read/write requests on a valid/ready interface, sequences them as BL single-beat accesses on the bank's `rd_o_wr`/`row`/`column`/`dqin`/`dqout` port, and returns assembled read bursts on a valid/ready response interface. Sits between the per-bank command path of the channel controller and one bank instance.

## Interface
- `DEVICE_WIDTH`, 4: bank data width in bits (one beat).
- `COLWIDTH`, 10: column address width.
- `CHWIDTH`, 5: row address width.
- `BL`, 8: beats per burst; must be at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  master idle and able to accept.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_row`  in  CHWIDTH  target row.
- `req_col`  in  COLWIDTH  start column.
- `req_wdata`  in  BL*DEVICE_WIDTH  write burst; beat k = `[k*DEVICE_WIDTH +: DEVICE_WIDTH]`.
- `rsp_valid`  out  1  read burst available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  BL*DEVICE_WIDTH  read burst, same beat packing.
- `rd_o_wr`  out  1  to bank: 1 = write this cycle.
- `row`  out  CHWIDTH  to bank.
- `column`  out  COLWIDTH  to bank.
- `dqin`  out  DEVICE_WIDTH  to bank write data.
- `dqout`  in  DEVICE_WIDTH  from bank; holds data for the address sampled at the previous edge.

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE: `req_ready`=1. Request is accepted on an edge with `req_valid && req_ready`. On acceptance, latch row, col, write flag and wdata; clear the beat counter; go to WRITE or READ.
- WRITE: per cycle, drive `rd_o_wr`=1, `row`=latched row, `column`=col+k, `dqin`=beat k. After beat BL-1, go to IDLE. Writes produce no response.
- READ: drive `rd_o_wr`=0 and issue columns col+k for k=0..BL-1. `dqout` is captured into beat k one edge after address k is presented. After the last issue, go to DRAIN, which captures the final beat and then goes to RESP.
- RESP: `rsp_valid`=1 and `rsp_rdata` is held stable until `rsp_ready`. Then go to IDLE.
- Column arithmetic is modulo 2^COLWIDTH. col+k wraps silently; there is no row increment.
- Bank outputs outside WRITE/READ: `rd_o_wr`=0, `row`=0, `column`=0, `dqin`=0.
- Request inputs are ignored whenever `req_ready`=0. `req_wdata` is only sampled at acceptance.

## Timing
- Reset (async assert, sync deassert edge): state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, and all bank outputs 0. Reset mid-burst aborts it immediately: no further bank writes occur and any partial read is discarded.
- All outputs are registered. Cycle 0 is the acceptance edge.
- Write: beat k is on the bank ports during cycle k+1, for k=0..BL-1. `req_ready` returns high in cycle BL+1, so back-to-back writes occupy BL+1 cycles each.
- Read:
  - Addresses are presented in cycles 1..BL.
  - Beat k is captured at the end of cycle k+2.
  - `rsp_valid` rises in cycle BL+2.
  - If `rsp_ready` is already high, `req_ready` returns in cycle BL+3.
- `rsp_ready` low stalls indefinitely in RESP. While `rsp_valid`=1, `rsp_rdata` must not change.
- `req_ready` is 0 in every state except IDLE, so a request cannot be accepted in the same cycle a response is consumed.

## Structure
- Package `bank_pkg`: state enum (`IDLE`, `WRITE`, `READ`, `DRAIN`, `RESP`) and the default `BL` localparam.
- One natural sub-module: `bank_beat_deser`, a BL×DEVICE_WIDTH capture register indexed by beat with a clear input. It is used for `rsp_rdata`.
- The beat counter and column adder stay in the top-level module.

## Test plan
- Write row 1, col 0, wdata 0x89ABCDEF (beat0=F … beat7=8) -> bank sees `rd_o_wr`=1 for cycles 1–8 with columns 0..7 and dqin F,E,D,C,B,A,9,8; `req_ready` high at cycle 9.
- Read row 1, col 0 after that write, `rsp_ready`=1 -> `rsp_valid` in cycle 10 with `rsp_rdata`=0x89ABCDEF.
- Write then read at col 1020 (COLWIDTH=10) -> columns 1020,1021,1022,1023,0,1,2,3; read data matches.
- Read with `rsp_ready` held 0 for 5 cycles -> `rsp_valid` stays 1, data stable, `req_ready`=0, and a `req_valid` asserted during the stall is not accepted.
- `rst_n` pulsed low at write beat 3 -> bank outputs 0 immediately, and columns 3..7 are never written. A subsequent read of columns 3..7 returns their pre-burst contents.
- Back-to-back write then read with `req_valid` held high -> second request accepted exactly in the cycle `req_ready` returns, with no gap or overlap on bank ports.
